// File: rtl/mips_boot_loader_pkg.sv
// Shared types for the MIPS boot loader: loader FSM states and word geometry.
package mips_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {HDR, PAY, SUM, DONE, ERR} ld_state_t;

endpackage

// File: rtl/mips_boot_loader_byte_packer.sv
// Packs accepted stream bytes into little-endian words; word_valid marks the
// cycle in which the final byte is being accepted, so word is usable that cycle.
module byte_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_fire,
  input  logic [7:0]        in_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [BYTE_CNT_W-1:0] cnt;
  logic [WORD_W-9:0]     lo;
  logic                  last;

  assign last       = (cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign word_valid = in_fire & last & ~clr;
  // Earlier bytes shift down from the top, so after three bytes lo = {b2,b1,b0}.
  assign word       = {in_data, lo};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      lo  <= '0;
    end else if (clr) begin
      cnt <= '0;
      lo  <= '0;
    end else if (in_fire) begin
      cnt <= last ? '0 : cnt + 1'b1;
      lo  <= {in_data, lo[WORD_W-9:8]};
    end
  end

endmodule

// File: rtl/mips_boot_loader.sv
// Byte-stream program loader for the MIPS core: header/payload/checksum parse,
// sequential imem writes, and core reset release once the image verifies.
module mips_boot_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [WORD_W-1:0] DEPTH = WORD_W'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]   ONE   = (ADDR_W + 1)'(1);

  ld_state_t         state, state_nxt;
  logic [ADDR_W:0]   n_words, word_idx;
  logic [WORD_W-1:0] sum, word;
  logic              word_valid, fire, restart, hdr_ok, last_pay;

  assign s_ready  = rst & ((state == HDR) | (state == PAY) | (state == SUM));
  assign fire     = s_valid & s_ready;
  assign restart  = reload & ((state == DONE) | (state == ERR));
  assign hdr_ok   = (word != '0) && (word <= DEPTH);
  assign last_pay = (word_idx == n_words - ONE);

  assign cpu_rst  = (state != DONE);
  assign done     = (state == DONE);
  assign err      = (state == ERR);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (restart),
    .in_fire    (fire),
    .in_data    (s_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HDR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR:       if (word_valid) state_nxt = hdr_ok ? PAY : ERR;
      PAY:       if (word_valid && last_pay) state_nxt = SUM;
      SUM:       if (word_valid) state_nxt = (word == sum) ? DONE : ERR;
      DONE, ERR: if (reload) state_nxt = HDR;
      default:   state_nxt = HDR;
    endcase
  end

  // Write port is registered: imem_we fires the cycle after a payload word completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_words    <= '0;
      word_idx   <= '0;
      sum        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (restart) begin
        n_words  <= '0;
        word_idx <= '0;
        sum      <= '0;
      end else if (word_valid) begin
        case (state)
          HDR: begin
            n_words  <= word[ADDR_W:0];
            word_idx <= '0;
            sum      <= '0;
          end
          PAY: begin
            imem_we    <= 1'b1;
            imem_addr  <= word_idx[ADDR_W-1:0];
            imem_wdata <= word;
            sum        <= sum + word;
            word_idx   <= word_idx + ONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader: good/bad images, header limits, stream gaps,
// mid-load reset and reload.
module tb_mips_boot_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0, rst = 1'b0, s_valid = 1'b0, reload = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_ready, imem_we, cpu_rst, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  int n_cmp = 0, n_bad = 0;
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];

  mips_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we === 1'b1) begin
    wa.push_back(imem_addr);
    wd.push_back(imem_wdata);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1; s_data = b;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0);
  endtask

  task automatic pulse_reload();
    reload = 1'b1; @(posedge clk); #1; reload = 1'b0;
  endtask

  task automatic settle();
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", imem_we); end
    n_cmp++; if (imem_addr !== '0 || imem_wdata !== '0) begin n_bad++; $display("FAIL reset_addr_data: got %h/%h want 0/0", imem_addr, imem_wdata); end
    n_cmp++; if ({cpu_rst, done, err} !== 3'b100) begin n_bad++; $display("FAIL reset_flags: got %b want 100", {cpu_rst, done, err}); end
    @(posedge clk); #1; rst = 1'b1; #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_good_image();
    logic [31:0] ew[3];
    ew = '{32'h11223344, 32'hAABBCCDD, 32'h00000001};
    wa.delete(); wd.delete();
    send_word(32'd3);
    for (int i = 0; i < 3; i++) send_word(ew[i]);
    send_byte(8'h22, 0); send_byte(8'h00, 0); send_byte(8'hDE, 0);
    n_cmp++; if ({done, cpu_rst} !== 2'b01) begin n_bad++; $display("FAIL good_pre_done: got %b want 01", {done, cpu_rst}); end
    send_byte(8'hBB, 0);
    n_cmp++; if ({done, cpu_rst, err} !== 3'b100) begin n_bad++; $display("FAIL good_done: got %b want 100", {done, cpu_rst, err}); end
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL good_ready_low: got %b want 0", s_ready); end
    settle();
    n_cmp++; if (wa.size() != 3) begin n_bad++; $display("FAIL good_write_count: got %0d want 3", wa.size()); end
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      n_cmp++;
      if (wa[i] !== ADDR_W'(i) || wd[i] !== ew[i]) begin
        n_bad++; $display("FAIL good_write%0d: got %h@%0d want %h@%0d", i, wd[i], wa[i], ew[i], i);
      end
    end
  endtask

  task automatic test_reload();
    pulse_reload();
    n_cmp++; if ({cpu_rst, done, err, s_ready} !== 4'b1001) begin n_bad++; $display("FAIL reload_flags: got %b want 1001", {cpu_rst, done, err, s_ready}); end
    wa.delete(); wd.delete();
    send_word(32'd2); send_word(32'hDEADBEEF); send_word(32'h00000002); send_word(32'hDEADBEF1);
    n_cmp++; if ({done, cpu_rst} !== 2'b10) begin n_bad++; $display("FAIL reload_done: got %b want 10", {done, cpu_rst}); end
    settle();
    n_cmp++;
    if (wa.size() != 2 || wa[0] !== 0 || wd[0] !== 32'hDEADBEEF || wa[1] !== 1 || wd[1] !== 32'h2) begin
      n_bad++; $display("FAIL reload_writes: got n=%0d %h %h want n=2 deadbeef 00000002", wa.size(), wd[0], wd[1]);
    end
  endtask

  task automatic test_bad_checksum();
    pulse_reload();
    wa.delete(); wd.delete();
    send_word(32'd3);
    pulse_reload();
    n_cmp++; if ({s_ready, err, cpu_rst} !== 3'b101) begin n_bad++; $display("FAIL badsum_reload_ignored: got %b want 101", {s_ready, err, cpu_rst}); end
    send_word(32'h11223344); send_word(32'hAABBCCDD); send_word(32'h00000001); send_word(32'hBBDE0023);
    n_cmp++; if ({err, cpu_rst, s_ready, done} !== 4'b1100) begin n_bad++; $display("FAIL badsum_flags: got %b want 1100", {err, cpu_rst, s_ready, done}); end
    s_valid = 1'b1; s_data = 8'h55;
    repeat (5) begin @(posedge clk); #1; end
    s_valid = 1'b0;
    settle();
    n_cmp++; if (wa.size() != 3 || wd[2] !== 32'h00000001) begin n_bad++; $display("FAIL badsum_writes: got n=%0d want 3", wa.size()); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL badsum_sticky: got %b want 1", err); end
  endtask

  task automatic test_bad_header();
    logic [31:0] w, sum, last_w;
    pulse_reload();
    wa.delete(); wd.delete();
    send_word(32'd0);
    n_cmp++; if ({err, cpu_rst} !== 2'b11) begin n_bad++; $display("FAIL hdr_zero_err: got %b want 11", {err, cpu_rst}); end
    pulse_reload();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL hdr_reload_clear: got %b want 0", err); end
    send_word(32'(DEPTH + 1));
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL hdr_big_err: got %b want 1", err); end
    settle();
    n_cmp++; if (wa.size() != 0) begin n_bad++; $display("FAIL hdr_no_writes: got %0d want 0", wa.size()); end
    pulse_reload();
    sum = 0; last_w = 0;
    send_word(32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      w = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
      sum += w; last_w = w;
      send_word(w);
    end
    send_word(sum);
    n_cmp++; if ({done, err} !== 2'b10) begin n_bad++; $display("FAIL hdr_depth_done: got %b want 10", {done, err}); end
    settle();
    n_cmp++;
    if (wa.size() != DEPTH || wa[DEPTH-1] !== ADDR_W'(DEPTH - 1) || wd[DEPTH-1] !== last_w) begin
      n_bad++; $display("FAIL hdr_depth_last: got n=%0d %h@%0d want n=%0d %h@%0d", wa.size(), wd[wa.size()-1], wa[wa.size()-1], DEPTH, last_w, DEPTH - 1);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] img[5];
    logic        exp_we;
    img = '{32'd3, 32'h11223344, 32'hAABBCCDD, 32'h00000001, 32'hBBDE0022};
    pulse_reload();
    wa.delete(); wd.delete();
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(img[j][8*k +: 8], int'($urandom_range(0, 3)));
        exp_we = (j >= 1 && j <= 3 && k == 3);
        n_cmp++; if (imem_we !== exp_we) begin n_bad++; $display("FAIL gaps_we_w%0d_b%0d: got %b want %b", j, k, imem_we, exp_we); end
        if (exp_we) begin
          n_cmp++;
          if (imem_addr !== ADDR_W'(j - 1) || imem_wdata !== img[j]) begin
            n_bad++; $display("FAIL gaps_write%0d: got %h@%0d want %h@%0d", j - 1, imem_wdata, imem_addr, img[j], j - 1);
          end
        end
      end
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL gaps_done: got %b want 1", done); end
    settle();
    n_cmp++; if (wa.size() != 3) begin n_bad++; $display("FAIL gaps_write_count: got %0d want 3", wa.size()); end
  endtask

  task automatic test_reset_midload();
    pulse_reload();
    send_word(32'd3);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    rst = 1'b0; #1;
    n_cmp++; if ({s_ready, cpu_rst, done} !== 3'b010) begin n_bad++; $display("FAIL midrst_flags: got %b want 010", {s_ready, cpu_rst, done}); end
    @(posedge clk); #1; rst = 1'b1;
    wa.delete(); wd.delete();
    send_word(32'd3); send_word(32'h11223344); send_word(32'hAABBCCDD);
    send_word(32'h00000001); send_word(32'hBBDE0022);
    n_cmp++; if ({done, cpu_rst} !== 2'b10) begin n_bad++; $display("FAIL midrst_done: got %b want 10", {done, cpu_rst}); end
    settle();
    n_cmp++;
    if (wa.size() != 3 || wa[0] !== 0 || wd[0] !== 32'h11223344) begin
      n_bad++; $display("FAIL midrst_first_write: got n=%0d %h@%0d want n=3 11223344@0", wa.size(), wd[0], wa[0]);
    end
  endtask

  initial begin
    test_reset();
    test_good_image();
    test_reload();
    test_bad_checksum();
    test_bad_header();
    test_gaps();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
